// File: rtl/pacote_ritmo.sv
// Shared definitions for the rhythm game: FSM states, command codes and scoring rules.
// Score increments grow with the current hit streak and the total saturates at 1023.
package pacote_ritmo;

   typedef enum logic [2:0] {
      EstOcioso,
      EstPedir,
      EstEspera,
      EstJanela,
      EstFim
   } estado_t;

   localparam logic [3:0] REPOUSO  = 4'd0;
   localparam logic [3:0] CIMA     = 4'd1;
   localparam logic [3:0] BAIXO    = 4'd2;
   localparam logic [3:0] ESQUERDA = 4'd4;
   localparam logic [3:0] DIREITA  = 4'd8;

   localparam logic [9:0] INC_BASE  = 10'd1;
   localparam logic [9:0] INC_MEDIO = 10'd2;
   localparam logic [9:0] INC_ALTO  = 10'd4;

   localparam logic [7:0] LIMIAR_MEDIO = 8'd4;
   localparam logic [7:0] LIMIAR_ALTO  = 8'd8;

   localparam logic [9:0] PONTUACAO_MAX = 10'd1023;
   localparam logic [7:0] SEQUENCIA_MAX = 8'd255;

   // Streak is the value before the current hit is counted.
   function automatic logic [9:0] somar_pontos(input logic [9:0] pontos,
                                               input logic [7:0] seq);
      logic [9:0]  inc;
      logic [10:0] soma;
      if (seq < LIMIAR_MEDIO) begin
         inc = INC_BASE;
      end else if (seq < LIMIAR_ALTO) begin
         inc = INC_MEDIO;
      end else begin
         inc = INC_ALTO;
      end
      soma = {1'b0, pontos} + {1'b0, inc};
      return soma[10] ? PONTUACAO_MAX : soma[9:0];
   endfunction

endpackage

// File: rtl/detector_de_borda.sv
// Rising-edge detector for the synchronized player buttons.
// A button held high produces a single press on the cycle it rises.
module detector_de_borda #(
   parameter int unsigned LARGURA = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [LARGURA-1:0] botoes,
   output logic [LARGURA-1:0] press
);

   logic [LARGURA-1:0] anterior_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         anterior_q <= '0;
      end else begin
         anterior_q <= botoes;
      end
   end

   assign press = botoes & ~anterior_q;

endmodule

// File: rtl/avaliador_de_comandos.sv
// Judges player button presses against the current command inside a timed window,
// keeping score, hit streak and lives, and requesting the next command after each window.
module avaliador_de_comandos
   import pacote_ritmo::*;
#(
   parameter int unsigned JANELA         = 25_000_000,
   parameter int unsigned VIDAS_INICIAIS = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iniciar,
   input  logic [3:0] comando,
   input  logic       fim_de_jogo,
   input  logic [3:0] botoes,
   output logic       trocar_comando,
   output logic [9:0] pontuacao,
   output logic [7:0] sequencia,
   output logic [1:0] vidas,
   output logic       acerto,
   output logic       erro,
   output logic       jogo_ativo,
   output logic       game_over,
   output logic       vitoria
);

   localparam int unsigned LARGURA_CONT = (JANELA > 1) ? $clog2(JANELA) : 1;
   localparam logic [LARGURA_CONT-1:0] ULTIMO = LARGURA_CONT'(JANELA - 1);

   estado_t                 estado_q, estado_d;
   logic [9:0]              pont_q, pont_d;
   logic [7:0]              seq_q, seq_d;
   logic [1:0]              vidas_q, vidas_d;
   logic [LARGURA_CONT-1:0] cont_q, cont_d;
   logic                    go_q, go_d;
   logic                    vit_q, vit_d;
   logic [3:0]              press;
   logic                    acertou, errou;

   detector_de_borda #(
      .LARGURA (4)
   ) u_borda (
      .clk    (clk),
      .rst    (rst),
      .botoes (botoes),
      .press  (press)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q <= EstOcioso;
         pont_q   <= '0;
         seq_q    <= '0;
         vidas_q  <= '0;
         cont_q   <= '0;
         go_q     <= 1'b0;
         vit_q    <= 1'b0;
      end else begin
         estado_q <= estado_d;
         pont_q   <= pont_d;
         seq_q    <= seq_d;
         vidas_q  <= vidas_d;
         cont_q   <= cont_d;
         go_q     <= go_d;
         vit_q    <= vit_d;
      end
   end

   always_comb begin
      estado_d       = estado_q;
      pont_d         = pont_q;
      seq_d          = seq_q;
      vidas_d        = vidas_q;
      cont_d         = cont_q;
      go_d           = go_q;
      vit_d          = vit_q;
      trocar_comando = 1'b0;
      acertou        = 1'b0;
      errou          = 1'b0;

      unique case (estado_q)
         EstOcioso, EstFim: begin
            if (iniciar) begin
               pont_d   = '0;
               seq_d    = '0;
               vidas_d  = 2'(VIDAS_INICIAIS);
               go_d     = 1'b0;
               vit_d    = 1'b0;
               estado_d = EstPedir;
            end
         end
         EstPedir: begin
            trocar_comando = 1'b1;
            estado_d       = EstEspera;
         end
         EstEspera: begin
            if (fim_de_jogo) begin
               vit_d    = 1'b1;
               estado_d = EstFim;
            end else begin
               cont_d   = '0;
               estado_d = EstJanela;
            end
         end
         EstJanela: begin
            cont_d = cont_q + 1'b1;
            // A press in the final cycle is judged before the timeout.
            if (comando != REPOUSO && press != 4'd0) begin
               acertou = (press == comando);
               errou   = (press != comando);
            end else if (cont_q == ULTIMO) begin
               errou    = (comando != REPOUSO);
               estado_d = EstPedir;
            end
            if (acertou) begin
               pont_d   = somar_pontos(pont_q, seq_q);
               seq_d    = (seq_q == SEQUENCIA_MAX) ? seq_q : seq_q + 8'd1;
               estado_d = EstPedir;
            end
            if (errou) begin
               seq_d   = '0;
               vidas_d = vidas_q - 2'd1;
               if (vidas_q <= 2'd1) begin
                  vidas_d  = '0;
                  go_d     = 1'b1;
                  estado_d = EstFim;
               end else begin
                  estado_d = EstPedir;
               end
            end
         end
         default: estado_d = EstOcioso;
      endcase
   end

   assign pontuacao  = pont_q;
   assign sequencia  = seq_q;
   assign vidas      = vidas_q;
   assign acerto     = acertou;
   assign erro       = errou;
   assign game_over  = go_q;
   assign vitoria    = vit_q;
   assign jogo_ativo = (estado_q == EstPedir) || (estado_q == EstEspera) ||
                       (estado_q == EstJanela);

endmodule

// File: doc/avaliador_de_comandos.md
AVALIADOR_DE_COMANDOS -- requirements
Module: avaliador_de_comandos

Interface
REQ-001 SHALL have parameter JANELA, default 25_000_000, clock cycles a command stays open for the player.
REQ-002 SHALL have parameter VIDAS_INICIAIS, default 3, lives loaded at game start (1..3).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port iniciar  input  1  start request, level sampled each cycle.
REQ-006 SHALL have port comando  input  4  current command from pattern manager: 0 = rest, 1/2/4/8 = one-hot direction.
REQ-007 SHALL have port fim_de_jogo  input  1  pattern manager end-of-list flag.
REQ-008 SHALL have port botoes  input  4  player buttons, already synchronized, active-high level.
REQ-009 SHALL have port trocar_comando  output  1  one-cycle pulse requesting the next command.
REQ-010 SHALL have port pontuacao  output  10  score.
REQ-011 SHALL have port sequencia  output  8  consecutive-hit streak.
REQ-012 SHALL have port vidas  output  2  remaining lives.
REQ-013 SHALL have ports acerto and erro  output  1 each  one-cycle hit / miss pulses.
REQ-014 SHALL have ports jogo_ativo, game_over, vitoria  output  1 each  status levels.

Function
REQ-015 SHALL implement FSM states OCIOSO, PEDIR, ESPERA, JANELA, FIM.
REQ-016 OCIOSO: when iniciar=1, clear pontuacao/sequencia, load vidas=VIDAS_INICIAIS, go to PEDIR.
REQ-017 PEDIR: drive trocar_comando=1 for exactly this cycle, go to ESPERA.
REQ-018 ESPERA: one settle cycle; if fim_de_jogo=1 go to FIM with vitoria=1, else clear window counter and go to JANELA.
REQ-019 Button press SHALL be rising edge only: press = botoes AND NOT botoes registered previous cycle; held buttons never re-trigger.
REQ-020 JANELA with comando≠0: first cycle with press≠0 judges; press==comando exactly -> hit, any other nonzero press (including multiple bits) -> miss; then go to PEDIR.
REQ-021 JANELA counter reaching JANELA-1 without a press -> miss, go to PEDIR; a press in that same final cycle SHALL take priority over timeout.
REQ-022 JANELA with comando=0 (rest): presses ignored, no pulses, no score change; go to PEDIR at timeout.
REQ-023 Hit: acerto pulse; pontuacao += 1 if sequencia<4, 2 if sequencia<8, else 4; saturate at 1023; sequencia += 1 saturating at 255.
REQ-024 Miss: erro pulse; sequencia=0; vidas -= 1; if vidas becomes 0 go to FIM with game_over=1 instead of PEDIR.
REQ-025 FIM: outputs frozen, no trocar_comando; iniciar=1 restarts exactly as REQ-016, clearing game_over/vitoria.
REQ-026 iniciar SHALL be ignored in PEDIR, ESPERA, JANELA.
REQ-027 jogo_ativo SHALL be 1 in PEDIR, ESPERA, JANELA; 0 otherwise.
REQ-028 acerto and erro SHALL never be high in the same cycle.

Reset
REQ-029 rst=1 SHALL immediately force OCIOSO, pontuacao=0, sequencia=0, vidas=0, all pulses and status outputs 0, counter and button register 0, regardless of state, including mid-window.

Structure
REQ-030 State encoding, command codes (REPOUSO=0, CIMA=1, BAIXO=2, ESQUERDA=4, DIREITA=8), and score increments SHALL live in shared package pacote_ritmo.
REQ-031 Button edge detection SHALL be sub-module detector_de_borda (4-bit, clk/rst, output press).

Verification (JANELA=8, VIDAS_INICIAIS=3)
REQ-032 Reset mid-JANELA with pontuacao=5 -> next cycle OCIOSO, all outputs 0, no trocar_comando.
REQ-033 iniciar, comando=2, press botoes=2 on window cycle 3 -> acerto pulse, pontuacao=1, sequencia=1, trocar_comando pulse 1 cycle later.
REQ-034 Nine consecutive hits -> pontuacao=1+1+1+1+2+2+2+2+4=16, sequencia=9.
REQ-035 comando=4, botoes=6 pressed -> erro, vidas=2, sequencia=0; three misses by timeout -> game_over=1, vidas=0, FIM.
REQ-036 comando=0 with random presses -> no acerto/erro, score unchanged, trocar_comando after 8 cycles.
REQ-037 fim_de_jogo=1 during ESPERA -> vitoria=1, jogo_ativo=0; button held across two windows counts only once.
